// File: rtl/frac_lut4_cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// frac_lut4_cfg_ctrl_pkg
// Shared constants for the frac_lut4 configuration controller: per-LUT
// configuration width, mode bit position and FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package frac_lut4_cfg_ctrl_pkg;

  // 16 sram bits plus one mode bit per frac_lut4
  localparam int FRAC_LUT4_CFG_BITS = 17;
  localparam int MODE_BIT           = 16;

  // Controller state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/frac_lut4_cfg_ser.sv
`default_nettype none
// ============================================================================
// frac_lut4_cfg_ser
// Combinational serial-bit selector. The flattened store is laid out so that
// the counter value is directly the bit position to emit.
// Revision: 1.0 - initial release
// ============================================================================
module frac_lut4_cfg_ser #(
  parameter int TOTAL_BITS = 68,
  parameter int CNT_W      = 7
) (
  input  logic [TOTAL_BITS-1:0] store_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic                  bit_o
);

  // Explicit compare-based mux keeps out-of-range counter codes at 0
  always_comb begin
    bit_o = 1'b0;
    for (int i = 0; i < TOTAL_BITS; i++) begin
      if (cnt_i == CNT_W'(i)) begin
        bit_o = store_i[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frac_lut4_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// frac_lut4_cfg_ctrl
// Shadow configuration store for a chain of frac_lut4 instances. Writes land
// in the shadow store; a commit shifts the whole store out serially, highest
// LUT first and mode bit first within each LUT.
// Revision: 1.0 - initial release
// ============================================================================
module frac_lut4_cfg_ctrl
  import frac_lut4_cfg_ctrl_pkg::*;
#(
  parameter int NUM_LUTS = 4,
  parameter int CFG_BITS = FRAC_LUT4_CFG_BITS,
  localparam int ADDR_W     = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1,
  localparam int TOTAL_BITS = NUM_LUTS * CFG_BITS,
  localparam int CNT_W      = $clog2(TOTAL_BITS)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [MODE_BIT:0] cfg_data,
  input  logic              commit_req,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done
);

  // Store layout: LUT i occupies [i*CFG_BITS +: CFG_BITS] as {mode, sram[15:0]},
  // so counting down from TOTAL_BITS-1 yields the required emission order.
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] store_q, store_d;
  logic                  ser_bit;

  // Next-state and bit counter; the counter stops at zero and never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (commit_req) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(TOTAL_BITS - 1);
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow store write; addresses beyond NUM_LUTS match no slot and are dropped
  always_comb begin
    store_d = store_q;
    if (cfg_valid && cfg_ready) begin
      for (int i = 0; i < NUM_LUTS; i++) begin
        if (cfg_addr == ADDR_W'(i)) begin
          store_d[i*CFG_BITS +: CFG_BITS] = cfg_data;
        end
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

  frac_lut4_cfg_ser #(
    .TOTAL_BITS (TOTAL_BITS),
    .CNT_W      (CNT_W)
  ) u_ser (
    .store_i (store_q),
    .cnt_i   (cnt_q),
    .bit_o   (ser_bit)
  );

  // Outputs decode from registered state, so reset clears them immediately
  assign cfg_ready = (state_q == IDLE);
  assign ccff_en   = (state_q == SHIFT);
  assign ccff_head = (state_q == SHIFT) & ser_bit;
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_frac_lut4_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frac_lut4_cfg_ctrl
// Directed bench for the configuration controller (4-LUT and 6-LUT builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_frac_lut4_cfg_ctrl;

  localparam int N   = 4;
  localparam int TOT = N * 17;
  localparam int NB   = 6;
  localparam int TOTB = NB * 17;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-LUT instance
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_addr  = '0;
  logic [16:0] cfg_data  = '0;
  logic        commit_req = 1'b0;
  logic        ccff_head, ccff_en, busy, done;

  frac_lut4_cfg_ctrl #(.NUM_LUTS(N)) dut (
    .prog_clk   (clk),
    .pReset     (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .commit_req (commit_req),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .busy       (busy),
    .done       (done)
  );

  // 6-LUT instance for the out-of-range address case
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [2:0]  b_addr  = '0;
  logic [16:0] b_data  = '0;
  logic        b_commit = 1'b0;
  logic        b_head, b_en, b_busy, b_done;

  frac_lut4_cfg_ctrl #(.NUM_LUTS(NB)) dut_b (
    .prog_clk   (clk),
    .pReset     (rst),
    .cfg_valid  (b_valid),
    .cfg_ready  (b_ready),
    .cfg_addr   (b_addr),
    .cfg_data   (b_data),
    .commit_req (b_commit),
    .ccff_head  (b_head),
    .ccff_en    (b_en),
    .busy       (b_busy),
    .done       (b_done)
  );

  logic [16:0]    model [N];
  logic [TOT-1:0] stream;
  int             n_en, n_done, n_bad;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected emission: LUT N-1 down to 0, each mode then sram15..sram0
  function automatic logic [TOT-1:0] exp_stream();
    logic [TOT-1:0] s;
    int k;
    s = '0;
    k = 0;
    for (int l = N - 1; l >= 0; l--) begin
      for (int b = 16; b >= 0; b--) begin
        s[k] = model[l][b];
        k++;
      end
    end
    return s;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [16:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    model[a]  = d;
  endtask

  // Issues a commit and follows the next TOT+5 cycles relative to acceptance.
  // pulse_at: cycle at which a stray commit_req is driven; hold_valid keeps a
  // write request pending during the shift; rst_at: cycle at which reset hits.
  task automatic run_commit(input int pulse_at, input bit hold_valid, input int rst_at);
    bit aborted, exp_busy, exp_done, exp_en;
    stream = '0;
    n_en = 0; n_done = 0; n_bad = 0;
    commit_req = 1'b1;
    @(posedge clk); #1;
    commit_req = 1'b0;
    cfg_valid  = hold_valid;
    if (hold_valid) begin
      cfg_addr = 2'd1;
      cfg_data = 17'h1_5555;
    end
    for (int j = 1; j <= TOT + 5; j++) begin
      if (j == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_en",   ccff_en, 0);
        chk("rst_mid_busy", busy,    0);
        chk("rst_mid_done", done,    0);
      end
      if (j == rst_at + 1) rst = 1'b0;
      if (j >= TOT + 1) cfg_valid = 1'b0;
      aborted  = (rst_at > 0) && (j >= rst_at);
      exp_busy = !aborted && (j <= TOT + 1);
      exp_done = !aborted && (j == TOT + 1);
      exp_en   = !aborted && (j <= TOT);
      if (busy !== exp_busy || done !== exp_done || cfg_ready !== !exp_busy ||
          ccff_en !== exp_en || (!ccff_en && ccff_head !== 1'b0))
        n_bad++;
      if (ccff_en === 1'b1) begin
        if (n_en < TOT) stream[n_en] = ccff_head;
        n_en++;
      end
      if (done === 1'b1) n_done++;
      commit_req = (j == pulse_at);
      @(posedge clk); #1;
    end
    commit_req = 1'b0;
    cfg_valid  = 1'b0;
    rst        = 1'b0;
  endtask

  logic [TOTB-1:0] b_stream, b_exp;
  logic [16:0]     b_lut5;
  int              b_n_en, b_n_done;

  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;

    // Reset state
    #2;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy",  busy,      0);
    chk("rst_done",  done,      0);
    chk("rst_en",    ccff_en,   0);
    chk("rst_head",  ccff_head, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst", cfg_ready, 1);
    repeat (3) @(posedge clk);
    #1;

    // Commit of an unwritten store: all zeros
    run_commit(-1, 1'b0, -1);
    chk("zero_stream", stream, '0);
    chk("zero_n_en",   n_en,   TOT);
    chk("zero_done",   n_done, 1);
    chk("zero_timing", n_bad,  0);

    // LUT0=1_8000, LUT3=0_0001
    wr(2'd0, 17'h1_8000);
    wr(2'd3, 17'h0_0001);
    run_commit(-1, 1'b0, -1);
    chk("w03_stream", stream, exp_stream());
    chk("w03_bit0",   stream[0],  0);
    chk("w03_bit16",  stream[16], 1);
    chk("w03_bit51",  stream[51], 1);
    chk("w03_bit52",  stream[52], 1);
    chk("w03_n_en",   n_en,   TOT);
    chk("w03_done",   n_done, 1);
    chk("w03_timing", n_bad,  0);

    // Write LUT2 in the same cycle as the commit
    cfg_valid = 1'b1;
    cfg_addr  = 2'd2;
    cfg_data  = 17'h1_FFFF;
    model[2]  = 17'h1_FFFF;
    run_commit(-1, 1'b0, -1);
    chk("same_cyc_bits17_33", stream[33:17], 17'h1_FFFF);
    chk("same_cyc_stream",    stream, exp_stream());
    chk("same_cyc_done",      n_done, 1);
    chk("same_cyc_timing",    n_bad,  0);

    // Stray commit mid-shift and a pending write held through the shift
    run_commit(30, 1'b1, -1);
    chk("stray_stream", stream, exp_stream());
    chk("stray_n_en",   n_en,   TOT);
    chk("stray_done",   n_done, 1);
    chk("stray_timing", n_bad,  0);
    run_commit(-1, 1'b0, -1);
    chk("stray_store_kept", stream, exp_stream());
    chk("stray_store_done", n_done, 1);

    // Reset mid-shift clears everything; the next commit emits zeros
    run_commit(-1, 1'b0, 20);
    for (int i = 0; i < N; i++) model[i] = '0;
    chk("abort_n_en",   n_en,   19);
    chk("abort_done",   n_done, 0);
    chk("abort_timing", n_bad,  0);
    run_commit(-1, 1'b0, -1);
    chk("post_abort_stream", stream, '0);
    chk("post_abort_n_en",   n_en,   TOT);
    chk("post_abort_done",   n_done, 1);

    // 6-LUT build: writes to addresses 6 and 7 are dropped
    b_lut5 = 17'h1_2345;
    b_valid = 1'b1; b_addr = 3'd5; b_data = b_lut5;
    @(posedge clk); #1;
    b_addr = 3'd6; b_data = 17'h1_FFFF;
    @(posedge clk); #1;
    b_addr = 3'd7; b_data = 17'h1_FFFF;
    @(posedge clk); #1;
    b_valid  = 1'b0;
    b_commit = 1'b1;
    @(posedge clk); #1;
    b_commit = 1'b0;
    b_stream = '0; b_n_en = 0; b_n_done = 0;
    for (int j = 0; j < TOTB + 10; j++) begin
      if (b_en === 1'b1) begin
        if (b_n_en < TOTB) b_stream[b_n_en] = b_head;
        b_n_en++;
      end
      if (b_done === 1'b1) b_n_done++;
      @(posedge clk); #1;
    end
    b_exp = '0;
    for (int k = 0; k < 17; k++) b_exp[k] = b_lut5[16-k];
    chk("n6_stream", b_stream, b_exp);
    chk("n6_n_en",   b_n_en,   TOTB);
    chk("n6_done",   b_n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frac_lut4_cfg_ctrl.md
FRAC_LUT4_CFG_CTRL -- requirements
Module: frac_lut4_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LUTS, default 4, meaning the number of frac_lut4 instances on the configuration chain (legal range 1..64).
REQ-002 The block SHALL have parameter CFG_BITS, default 17, meaning the bits per LUT: 16 sram plus 1 mode.
REQ-003 The block SHALL have port prog_clk, input, width 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port pReset, input, width 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port cfg_valid, input, width 1, a write request for one LUT configuration.
REQ-006 The block SHALL have port cfg_ready, output, width 1, indicating that a write is accepted this cycle.
REQ-007 The block SHALL have port cfg_addr, input, width clog2(NUM_LUTS) (minimum 1), giving the LUT index to write.
REQ-008 The block SHALL have port cfg_data, input, width 17: bits [15:0] are sram[15:0] and bit [16] is mode.
REQ-009 The block SHALL have port commit_req, input, width 1, requesting that the shadow configuration be shifted into the chain.
REQ-010 The block SHALL have port ccff_head, output, width 1, carrying serial configuration data to the chain head.
REQ-011 The block SHALL have port ccff_en, output, width 1, a chain shift enable that is high exactly in the cycles in which ccff_head is valid.
REQ-012 The block SHALL have port busy, output, width 1, high from commit acceptance until done.
REQ-013 The block SHALL have port done, output, width 1, a one-cycle pulse marking commit completion.

Function
REQ-014 The block SHALL hold a shadow store of NUM_LUTS x 17 bits.
REQ-015 Write handshake: a write SHALL occur on a cycle with cfg_valid&&cfg_ready, storing cfg_data at cfg_addr.
REQ-016 The block SHALL drive cfg_ready = (state==IDLE) combinationally.
REQ-017 When cfg_addr >= NUM_LUTS during a handshake, the block SHALL ignore the write and leave the store unchanged.
REQ-018 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-019 In IDLE, commit_req=1 SHALL load the bit counter with NUM_LUTS*CFG_BITS-1 and transition to SHIFT.
REQ-020 In SHIFT, each cycle SHALL drive ccff_en=1 and ccff_head = the current serial bit, then decrement the counter; the transition to DONE SHALL occur on the cycle the counter reaches 0 (after exactly NUM_LUTS*CFG_BITS SHIFT cycles).
REQ-021 In DONE, the block SHALL assert done=1 for one cycle and return to IDLE.
REQ-022 Serial order SHALL be LUT index descending; within each LUT, mode first, then sram[15] down to sram[0].
REQ-023 The first emitted bit SHALL be LUT[NUM_LUTS-1].mode and the last emitted bit SHALL be LUT[0].sram[0].
REQ-024 Latency: for commit accepted at cycle t, SHIFT SHALL occupy cycles t+1..t+NUM_LUTS*CFG_BITS and done SHALL pulse at cycle t+NUM_LUTS*CFG_BITS+1.
REQ-025 busy SHALL be high in SHIFT and DONE.
REQ-026 In IDLE and DONE, ccff_en SHALL be 0 and ccff_head SHALL be 0.
REQ-027 Simultaneous cfg handshake and commit_req in IDLE: the write SHALL take effect and the commit SHALL shift the updated data.
REQ-028 A commit_req outside IDLE SHALL be ignored and not queued.
REQ-029 The bit counter SHALL be clog2(NUM_LUTS*CFG_BITS) bits wide and SHALL never wrap; no decrement occurs below 0.
REQ-030 commit_req with an unwritten store SHALL shift the reset contents (all zeros).

Reset
REQ-031 While pReset=1, independent of prog_clk, the block SHALL force state=IDLE, counter=0, shadow store=0, and ccff_en, ccff_head, busy and done to 0.
REQ-032 Reset asserted mid-SHIFT SHALL abort immediately with no done pulse; the chain contents are then undefined until the next commit.
REQ-033 After pReset deasserts, cfg_ready SHALL be 1 in the first cycle.

Structure
REQ-034 The shared package SHALL contain FRAC_LUT4_CFG_BITS=17, the MODE_BIT index 16, and the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
REQ-035 The block SHALL use one sub-module, frac_lut4_cfg_ser, which selects the serial bit from the store by counter value (purely combinational).
REQ-036 The FSM, counter and shadow store SHALL reside in the top module.

Verification (NUM_LUTS=4)
REQ-037 Write LUT0=17'h1_8000, LUT3=17'h0_0001, then commit -> 68 ccff_en cycles; bit0=0 (LUT3.mode), bit16=1 (LUT3.sram0), bit51=1 (LUT0.mode), bit52=1 (LUT0.sram15), and all other bits 0.
REQ-038 Commit at cycle 10 -> busy high cycles 11..79, done pulse at cycle 79 only, cfg_ready low cycles 11..79.
REQ-039 Write LUT2=17'h1_FFFF together with commit_req in the same cycle -> bits 17..33 of the stream all 1.
REQ-040 commit_req pulsed at SHIFT cycle 30 and cfg_valid held high throughout the shift -> stream unchanged, store unchanged, exactly one done.
REQ-041 pReset asserted at SHIFT cycle 20 -> ccff_en=0, busy=0 and store=0 immediately; no done; a following commit emits 68 zeros.
REQ-042 Write with cfg_addr=5 (NUM_LUTS=6 build, addr 6 and 7) -> with N=6 and addr 6, the write is ignored and the store is unchanged.
